data_sram_bridge: RTL and testbench

Memory-stage bridge between the pipelined datapath's single-cycle data-memory port and an SRAM-like split-handshake bus (`addr_ok` / `data_ok`).
- Accepts one load or store per memory-stage instruction and registers the request.
- Holds the pipeline via `cpu_stall` until the response returns.
- Keeps read data stable while the rest of the pipeline is still stalled.

---
 rtl/data_sram_bridge.sv | 132 +++++++++++++
 tb/tb_data_sram_bridge.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_sram_bridge.sv
// Memory-stage bridge: single-cycle data port to SRAM-like split-handshake bus (addr_ok / data_ok).
// Optional misaligned-access rejection is enabled by defining DATA_BRIDGE_ALIGN_CHK_EN.
module data_sram_bridge #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_en,
  input  logic [3:0]    cpu_wen,
  input  logic [1:0]    cpu_size,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic          cpu_longest_stall,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  output logic          align_err,
  output logic          data_req,
  output logic          data_wr,
  output logic [1:0]    data_size,
  output logic [AW-1:0] data_addr,
  output logic [3:0]    data_wstrb,
  output logic [DW-1:0] data_wdata,
  input  logic          data_addr_ok,
  input  logic          data_data_ok,
  input  logic [DW-1:0] data_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} stateT;

  stateT         state;
  stateT         stateNext;
  logic          reqWr;
  logic [3:0]    reqWen;
  logic [1:0]    reqSize;
  logic [AW-1:0] reqAddr;
  logic [DW-1:0] reqWdata;
  logic [DW-1:0] rdataBuf;
  logic          misaligned;
  logic          accept;
  logic          captureRdata;

`ifdef DATA_BRIDGE_ALIGN_CHK_EN
  assign misaligned = cpu_en &&
                      (((cpu_size == 2'd2) && (cpu_addr[1:0] != 2'b00)) ||
                       ((cpu_size == 2'd1) && cpu_addr[0]));
`else
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= stateNext;
  end

  // Request registers hold the bus fields stable while waiting for addr_ok.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reqWr    <= 1'b0;
      reqWen   <= 4'h0;
      reqSize  <= 2'd0;
      reqAddr  <= '0;
      reqWdata <= '0;
    end else if (accept) begin
      reqWr    <= |cpu_wen;
      reqWen   <= cpu_wen;
      reqSize  <= cpu_size;
      reqAddr  <= cpu_addr;
      reqWdata <= cpu_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              rdataBuf <= '0;
    else if (captureRdata) rdataBuf <= data_rdata;
  end

  always_comb begin
    stateNext    = state;
    accept       = 1'b0;
    captureRdata = 1'b0;
    data_req     = 1'b0;
    data_wr      = 1'b0;
    data_size    = 2'd0;
    data_addr    = '0;
    data_wstrb   = 4'h0;
    data_wdata   = '0;
    cpu_stall    = 1'b0;
    align_err    = 1'b0;
    cpu_rdata    = rdataBuf;
    case (state)
      IDLE: begin
        align_err = misaligned;
        if (cpu_en && !misaligned) begin
          data_req   = 1'b1;
          data_wr    = |cpu_wen;
          data_size  = cpu_size;
          data_addr  = cpu_addr;
          data_wstrb = cpu_wen;
          data_wdata = cpu_wdata;
          cpu_stall  = 1'b1;
          accept     = 1'b1;
          stateNext  = data_addr_ok ? WAIT : REQ;
        end
      end
      REQ: begin
        data_req   = 1'b1;
        data_wr    = reqWr;
        data_size  = reqSize;
        data_addr  = reqAddr;
        data_wstrb = reqWen;
        data_wdata = reqWdata;
        cpu_stall  = 1'b1;
        if (data_addr_ok) stateNext = WAIT;
      end
      WAIT: begin
        // Forward bus data directly so the load completes in the data_ok cycle.
        cpu_rdata = data_rdata;
        cpu_stall = !data_data_ok;
        if (data_data_ok) begin
          captureRdata = 1'b1;
          stateNext    = cpu_longest_stall ? DONE : IDLE;
        end
      end
      DONE: begin
        if (!cpu_longest_stall) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_data_sram_bridge.sv
// Self-checking bench for data_sram_bridge: directed vector table, hand sequences, randomized run vs a flag-based model.
module tb_data_sram_bridge;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned RAND_CYCLES = 3000;

  logic          clk;
  logic          rst;
  logic          cpu_en;
  logic [3:0]    cpu_wen;
  logic [1:0]    cpu_size;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_longest_stall;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;
  logic          align_err;
  logic          data_req;
  logic          data_wr;
  logic [1:0]    data_size;
  logic [AW-1:0] data_addr;
  logic [3:0]    data_wstrb;
  logic [DW-1:0] data_wdata;
  logic          data_addr_ok;
  logic          data_data_ok;
  logic [DW-1:0] data_rdata;

  data_sram_bridge #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .cpu_en(cpu_en), .cpu_wen(cpu_wen), .cpu_size(cpu_size), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_longest_stall(cpu_longest_stall),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .align_err(align_err),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Transaction-level model: one outstanding access, its address-phase flag, and a post-response hold.
  bit            mBusy;
  bit            mAccepted;
  bit            mHeld;
  logic          mWr;
  logic [3:0]    mWen;
  logic [1:0]    mSize;
  logic [AW-1:0] mAddr;
  logic [DW-1:0] mWdata;
  logic [DW-1:0] mRbuf;

  typedef struct packed {
    logic          req;
    logic          stall;
    logic          align;
    logic [DW-1:0] rdata;
    logic          wr;
    logic [1:0]    size;
    logic [AW-1:0] addr;
    logic [3:0]    wstrb;
    logic [DW-1:0] wdata;
  } outT;

  typedef struct {
    logic          en;
    logic [AW-1:0] addr;
    logic          lng;
    logic          aok;
    logic          dok;
    logic [DW-1:0] brd;
    logic          expReq;
    logic          expStall;
    logic [DW-1:0] expRdata;
  } vecT;

  vecT vec [15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit isMisaligned(input logic en, input logic [1:0] size, input logic [AW-1:0] addr);
    bit chkOn;
`ifdef DATA_BRIDGE_ALIGN_CHK_EN
    chkOn = 1'b1;
`else
    chkOn = 1'b0;
`endif
    return chkOn && en && (((size == 2'd2) && (addr % 4 != 0)) || ((size == 2'd1) && (addr % 2 != 0)));
  endfunction

  function automatic outT expected();
    outT e;
    bit  idle;
    bit  mis;
    e    = '0;
    idle = !mBusy && !mHeld;
    mis  = isMisaligned(cpu_en, cpu_size, cpu_addr);
    e.rdata = (mBusy && mAccepted) ? data_rdata : mRbuf;
    if (idle) begin
      e.align = mis;
      if (cpu_en && !mis) begin
        e.req = 1'b1; e.stall = 1'b1; e.wr = |cpu_wen; e.size = cpu_size;
        e.addr = cpu_addr; e.wstrb = cpu_wen; e.wdata = cpu_wdata;
      end
    end else if (mBusy && !mAccepted) begin
      e.req = 1'b1; e.stall = 1'b1; e.wr = mWr; e.size = mSize;
      e.addr = mAddr; e.wstrb = mWen; e.wdata = mWdata;
    end else if (mBusy) begin
      e.stall = !data_data_ok;
    end
    return e;
  endfunction

  task automatic modelReset();
    mBusy = 0; mAccepted = 0; mHeld = 0;
    mWr = 1'b0; mWen = 4'h0; mSize = 2'd0; mAddr = '0; mWdata = '0; mRbuf = '0;
  endtask

  task automatic modelStep();
    if (!mBusy && !mHeld) begin
      if (cpu_en && !isMisaligned(cpu_en, cpu_size, cpu_addr)) begin
        mBusy = 1; mAccepted = data_addr_ok;
        mWr = |cpu_wen; mWen = cpu_wen; mSize = cpu_size; mAddr = cpu_addr; mWdata = cpu_wdata;
      end
    end else if (mBusy && !mAccepted) begin
      mAccepted = data_addr_ok;
    end else if (mBusy) begin
      if (data_data_ok) begin
        mRbuf = data_rdata; mBusy = 0; mAccepted = 0; mHeld = cpu_longest_stall;
      end
    end else if (mHeld && !cpu_longest_stall) begin
      mHeld = 0;
    end
  endtask

  // Called at the falling edge: compare every visible output against the model.
  task automatic checkModel();
    outT e;
    e = expected();
    check("data_req", 64'(data_req), 64'(e.req));
    check("cpu_stall", 64'(cpu_stall), 64'(e.stall));
    check("align_err", 64'(align_err), 64'(e.align));
    check("cpu_rdata", 64'(cpu_rdata), 64'(e.rdata));
    if (e.req) begin
      check("data_wr", 64'(data_wr), 64'(e.wr));
      check("data_size", 64'(data_size), 64'(e.size));
      check("data_addr", 64'(data_addr), 64'(e.addr));
      check("data_wstrb", 64'(data_wstrb), 64'(e.wstrb));
      check("data_wdata", 64'(data_wdata), 64'(e.wdata));
    end
  endtask

  task automatic advance();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic setLoad(input logic en, input logic [AW-1:0] addr);
    cpu_en = en; cpu_wen = 4'h0; cpu_size = 2'd2; cpu_addr = addr; cpu_wdata = '0;
  endtask

  function automatic vecT mk(input logic en, input logic [AW-1:0] addr, input logic lng,
                             input logic aok, input logic dok, input logic [DW-1:0] brd,
                             input logic eReq, input logic eStall, input logic [DW-1:0] eRd);
    vecT v;
    v.en = en; v.addr = addr; v.lng = lng; v.aok = aok; v.dok = dok; v.brd = brd;
    v.expReq = eReq; v.expStall = eStall; v.expRdata = eRd;
    return v;
  endfunction

  initial begin
    // Zero-wait load, longest-stall hold, flush in WAIT.
    vec[0]  = mk(1'b1, 32'h1000_0004, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0);
    vec[1]  = mk(1'b1, 32'h1000_0004, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'hDEAD_BEEF);
    vec[2]  = mk(1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'hDEAD_BEEF);
    vec[3]  = mk(1'b1, 32'h40,        1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'hDEAD_BEEF);
    vec[4]  = mk(1'b1, 32'h40,        1'b1, 1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h1234_5678);
    vec[5]  = mk(1'b1, 32'h40,        1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h1234_5678);
    vec[6]  = mk(1'b1, 32'h40,        1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h1234_5678);
    vec[7]  = mk(1'b1, 32'h40,        1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h1234_5678);
    vec[8]  = mk(1'b1, 32'h40,        1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h1234_5678);
    vec[9]  = mk(1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h1234_5678);
    vec[10] = mk(1'b1, 32'h80,        1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h1234_5678);
    vec[11] = mk(1'b1, 32'h80,        1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h1234_5678);
    vec[12] = mk(1'b0, 32'h80,        1'b0, 1'b0, 1'b0, 32'hAAAA_0000, 1'b0, 1'b1, 32'hAAAA_0000);
    vec[13] = mk(1'b0, 32'h80,        1'b0, 1'b0, 1'b1, 32'h0BAD_F00D, 1'b0, 1'b0, 32'h0BAD_F00D);
    vec[14] = mk(1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0BAD_F00D);

    // Reset state.
    rst = 1'b0;
    setLoad(1'b0, '0);
    cpu_longest_stall = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
    modelReset();
    #2;
    check("rst_req", 64'(data_req), 64'(0));
    check("rst_stall", 64'(cpu_stall), 64'(0));
    check("rst_align", 64'(align_err), 64'(0));
    check("rst_rdata", 64'(cpu_rdata), 64'(0));
    check("rst_bus", 64'({data_wr, data_size, data_wstrb}), 64'(0));
    check("rst_addr", 64'(data_addr), 64'(0));
    check("rst_wdata", 64'(data_wdata), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Directed vector table.
    for (int i = 0; i < 15; i++) begin
      setLoad(vec[i].en, vec[i].addr);
      cpu_longest_stall = vec[i].lng;
      data_addr_ok = vec[i].aok; data_data_ok = vec[i].dok; data_rdata = vec[i].brd;
      @(negedge clk);
      check($sformatf("vec%0d_req", i), 64'(data_req), 64'(vec[i].expReq));
      check($sformatf("vec%0d_stall", i), 64'(cpu_stall), 64'(vec[i].expStall));
      check($sformatf("vec%0d_rdata", i), 64'(cpu_rdata), 64'(vec[i].expRdata));
      checkModel();
      advance();
    end

    // Delayed-acceptance store; cpu_addr/wdata wander while the bus must hold the latched request.
    for (int i = 0; i < 4; i++) begin
      cpu_en = 1'b1; cpu_wen = 4'b0011; cpu_size = 2'd1; cpu_longest_stall = 1'b0;
      cpu_addr  = (i == 0) ? 32'h20 : 32'h998 + 32'(2 * i);
      cpu_wdata = (i == 0) ? 32'h0000_ABCD : $urandom;
      data_addr_ok = (i == 3); data_data_ok = 1'b0; data_rdata = $urandom;
      @(negedge clk);
      check("st_req", 64'(data_req), 64'(1));
      check("st_stall", 64'(cpu_stall), 64'(1));
      check("st_addr", 64'(data_addr), 64'(32'h20));
      check("st_wdata", 64'(data_wdata), 64'(32'h0000_ABCD));
      check("st_wstrb", 64'(data_wstrb), 64'(4'b0011));
      check("st_wr", 64'(data_wr), 64'(1));
      check("st_size", 64'(data_size), 64'(1));
      checkModel();
      advance();
    end
    cpu_en = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
    @(negedge clk);
    check("st_wait_req", 64'(data_req), 64'(0));
    check("st_wait_stall", 64'(cpu_stall), 64'(1));
    checkModel();
    advance();
    data_data_ok = 1'b1; data_rdata = 32'h5A5A_5A5A;
    @(negedge clk);
    check("st_done_stall", 64'(cpu_stall), 64'(0));
    checkModel();
    advance();
    data_data_ok = 1'b0;

    // Misaligned word load to 0x1002.
    setLoad(1'b1, 32'h1002);
`ifdef DATA_BRIDGE_ALIGN_CHK_EN
    data_addr_ok = 1'b0;
    @(negedge clk);
    check("mis_align", 64'(align_err), 64'(1));
    check("mis_req", 64'(data_req), 64'(0));
    check("mis_stall", 64'(cpu_stall), 64'(0));
    checkModel();
    advance();
`else
    data_addr_ok = 1'b1;
    @(negedge clk);
    check("mis_align", 64'(align_err), 64'(0));
    check("mis_req", 64'(data_req), 64'(1));
    check("mis_addr", 64'(data_addr), 64'(32'h1002));
    check("mis_stall", 64'(cpu_stall), 64'(1));
    checkModel();
    advance();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h600D_CAFE;
    @(negedge clk);
    check("mis_rdata", 64'(cpu_rdata), 64'(32'h600D_CAFE));
    check("mis_stall1", 64'(cpu_stall), 64'(0));
    checkModel();
    advance();
`endif
    setLoad(1'b0, '0); data_addr_ok = 1'b0; data_data_ok = 1'b0;
    @(negedge clk);
    checkModel();
    advance();

    // Reset asserted between clock edges while stuck in the address phase.
    setLoad(1'b1, 32'h300);
    @(negedge clk);
    checkModel();
    advance();
    cpu_en = 1'b0;
    #2;
    check("pre_rst_req", 64'(data_req), 64'(1));
    rst = 1'b0;
    #1;
    check("arst_req", 64'(data_req), 64'(0));
    check("arst_stall", 64'(cpu_stall), 64'(0));
    check("arst_addr", 64'(data_addr), 64'(0));
    check("arst_rdata", 64'(cpu_rdata), 64'(0));
    modelReset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Randomized run; the bus side honours the one-outstanding / data_ok-after-addr_ok contract.
    for (int n = 0; n < int'(RAND_CYCLES); n++) begin
      outT e;
      cpu_en            = ($urandom_range(0, 9) < 6);
      cpu_wen           = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      cpu_size          = 2'($urandom_range(0, 2));
      cpu_addr          = $urandom;
      cpu_wdata         = $urandom;
      cpu_longest_stall = ($urandom_range(0, 9) < 3);
      data_rdata        = $urandom;
      e = expected();
      data_addr_ok = e.req && ($urandom_range(0, 2) == 0);
      data_data_ok = mBusy && mAccepted && ($urandom_range(0, 2) == 0);
      @(negedge clk);
      checkModel();
      advance();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
